// File: rtl/mbc_windowed.sv
`default_nettype none
// ==========================================================================
// mbc_windowed : banked ROM/RAM mapper with one or two ROM windows,
//                optional zero-bank remap and a rumble hold timer. Rev 1.0
// ==========================================================================
module mbc_windowed #(
  parameter int NUM_WIN     = 1,
  parameter int ROM_BANK_W  = 9,
  parameter int RAM_BANK_W  = 4,
  parameter int ZERO_REMAP  = 0,
  parameter int RUMBLE      = 0,
  parameter int RUMBLE_HOLD = 4096
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_cpu,
  input  logic        enable,
  input  logic        savestate_load,
  input  logic [63:0] savestate_data,
  output logic [63:0] savestate_back,
  input  logic        has_ram,
  input  logic [3:0]  ram_mask,
  input  logic [8:0]  rom_mask,
  input  logic [14:0] cart_addr,
  input  logic        cart_a15,
  input  logic        cart_wr,
  input  logic [7:0]  cart_di,
  input  logic [7:0]  cram_di,
  output logic [7:0]  cram_do,
  output logic [16:0] cram_addr,
  output logic [22:0] mbc_addr,
  output logic        ram_enabled,
  output logic        rumble
);

  localparam int         RC_W        = $clog2(RUMBLE_HOLD + 1);
  localparam logic [3:0] RAM_WR_MASK = (RUMBLE != 0) ? 4'b0111 : 4'b1111;

  logic                  r_wr_q;
  logic                  r_armed;
  logic                  r_ram_en;
  logic [RAM_BANK_W-1:0] r_ram_bank;
  logic [ROM_BANK_W-1:0] r_bank [2];
  logic [RC_W-1:0]       r_rum_cnt;

  logic                  w_commit;
  logic                  w_win;
  logic [15:0]           w_bank_wide;
  logic [ROM_BANK_W-1:0] w_bank_new;
  logic [RAM_BANK_W-1:0] w_ram_bank_new;
  logic [22:0]           w_rom;
  logic [ROM_BANK_W-1:0] w_bank1_ss;
  logic                  w_ram_enabled;
  logic                  unused_ok;

  // r_armed blocks a write that was already in flight when reset released.
  assign w_commit = ce_cpu & cart_wr & ~r_wr_q & r_armed & ~cart_a15 & enable
                  & ~savestate_load;

  always_comb begin
    w_win       = (NUM_WIN == 2) ? cart_addr[11] : 1'b0;
    w_bank_wide = 16'(r_bank[w_win]);
    if (cart_addr[12]) w_bank_wide[15:8] = cart_di;
    else               w_bank_wide[7:0]  = cart_di;
    w_bank_new  = w_bank_wide[ROM_BANK_W-1:0];
    if (ZERO_REMAP != 0 && w_bank_new == '0) w_bank_new = ROM_BANK_W'(1);
  end

  assign w_ram_bank_new = RAM_BANK_W'(cart_di[3:0] & RAM_WR_MASK);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_wr_q     <= 1'b0;
      r_armed    <= ~cart_wr;
      r_ram_en   <= 1'b0;
      r_ram_bank <= '0;
      r_bank[0]  <= ROM_BANK_W'(1);
      r_bank[1]  <= ROM_BANK_W'(2);
      r_rum_cnt  <= '0;
    end else begin
      if (ce_cpu) begin
        r_wr_q <= cart_wr;
        if (!cart_wr) r_armed <= 1'b1;
      end
      if (savestate_load) begin
        r_ram_en   <= savestate_data[0];
        r_ram_bank <= RAM_BANK_W'(savestate_data[4:1]);
        r_bank[0]  <= ROM_BANK_W'(savestate_data[16:5]);
        r_bank[1]  <= ROM_BANK_W'(savestate_data[28:17]);
        r_rum_cnt  <= '0;
      end else begin
        if (r_rum_cnt != '0) r_rum_cnt <= r_rum_cnt - RC_W'(1);
        // The later set overrides the decrement, so a set always wins.
        if (w_commit) begin
          case (cart_addr[14:13])
            2'd0: r_ram_en <= (cart_di[3:0] == 4'hA);
            2'd1: r_bank[w_win] <= w_bank_new;
            2'd2: begin
              r_ram_bank <= w_ram_bank_new;
              if (RUMBLE != 0) r_rum_cnt <= cart_di[3] ? RC_W'(RUMBLE_HOLD) : '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    w_rom = {8'd0, cart_addr};
    if (cart_addr[14]) begin
      if (NUM_WIN == 2) w_rom = {10'(r_bank[cart_addr[13]]), cart_addr[12:0]};
      else              w_rom = {9'(r_bank[0]), cart_addr[13:0]};
      w_rom[22:14] = w_rom[22:14] & rom_mask;
    end
  end

  assign w_bank1_ss    = (NUM_WIN == 2) ? r_bank[1] : '0;
  assign w_ram_enabled = r_ram_en & has_ram;

  assign mbc_addr       = enable ? w_rom : '0;
  assign cram_addr      = enable ? {4'(r_ram_bank) & ram_mask, cart_addr[12:0]} : '0;
  assign ram_enabled    = enable & w_ram_enabled;
  assign cram_do        = (enable && w_ram_enabled) ? cram_di : 8'hFF;
  assign rumble         = enable & (r_rum_cnt != '0);
  assign savestate_back = enable ? {35'd0, 12'(w_bank1_ss), 12'(r_bank[0]),
                                    4'(r_ram_bank), r_ram_en} : '0;

  assign unused_ok = &{1'b0, savestate_data};

endmodule
`default_nettype wire

// File: tb/tb_mbc_windowed.sv
`default_nettype none
// Scoreboard bench: two mapper configurations driven in lockstep against a behavioural model.
module tb_mbc_windowed;
  localparam int PER    = 10;
  localparam int HOLD_A = 8;

  typedef struct packed {
    logic [22:0] mbc;
    logic [16:0] cram;
    logic [7:0]  cdo;
    logic        ren;
    logic        rum;
    logic [63:0] ss;
  } obs_t;

  logic clk_sys = 1'b0;
  always #(PER/2) clk_sys = ~clk_sys;

  logic        reset_n, ce_cpu, enable, savestate_load, has_ram, cart_a15, cart_wr, probe;
  logic [63:0] ss_data_a, ss_data_b;
  logic [3:0]  ram_mask;
  logic [8:0]  rom_mask;
  logic [14:0] cart_addr;
  logic [7:0]  cart_di, cram_di;

  logic [63:0] ss_back_a, ss_back_b;
  logic [7:0]  cram_do_a, cram_do_b;
  logic [16:0] cram_addr_a, cram_addr_b;
  logic [22:0] mbc_addr_a, mbc_addr_b;
  logic        ram_enabled_a, ram_enabled_b, rumble_a, rumble_b;

  mbc_windowed #(.NUM_WIN(1), .ROM_BANK_W(9), .RAM_BANK_W(4), .ZERO_REMAP(0),
                 .RUMBLE(1), .RUMBLE_HOLD(HOLD_A)) dut_a (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_cpu(ce_cpu), .enable(enable),
    .savestate_load(savestate_load), .savestate_data(ss_data_a), .savestate_back(ss_back_a),
    .has_ram(has_ram), .ram_mask(ram_mask), .rom_mask(rom_mask), .cart_addr(cart_addr),
    .cart_a15(cart_a15), .cart_wr(cart_wr), .cart_di(cart_di), .cram_di(cram_di),
    .cram_do(cram_do_a), .cram_addr(cram_addr_a), .mbc_addr(mbc_addr_a),
    .ram_enabled(ram_enabled_a), .rumble(rumble_a));

  mbc_windowed #(.NUM_WIN(2), .ROM_BANK_W(12), .RAM_BANK_W(4), .ZERO_REMAP(1),
                 .RUMBLE(0), .RUMBLE_HOLD(4096)) dut_b (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_cpu(ce_cpu), .enable(enable),
    .savestate_load(savestate_load), .savestate_data(ss_data_b), .savestate_back(ss_back_b),
    .has_ram(has_ram), .ram_mask(ram_mask), .rom_mask(rom_mask), .cart_addr(cart_addr),
    .cart_a15(cart_a15), .cart_wr(cart_wr), .cart_di(cart_di), .cram_di(cram_di),
    .cram_do(cram_do_b), .cram_addr(cram_addr_b), .mbc_addr(mbc_addr_b),
    .ram_enabled(ram_enabled_b), .rumble(rumble_b));

  obs_t obs_a, obs_b;
  assign obs_a = {mbc_addr_a, cram_addr_a, cram_do_a, ram_enabled_a, rumble_a, ss_back_a};
  assign obs_b = {mbc_addr_b, cram_addr_b, cram_do_b, ram_enabled_b, rumble_b, ss_back_b};

  // ---------------- reference model ----------------
  int unsigned m_bank [2][2];
  int unsigned m_rb [2];
  bit          m_ren [2];
  bit          m_rum_on [2];
  time         m_rum_t [2];

  obs_t q_a[$];
  obs_t q_b[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int cfg_nw(input int d);  return (d == 0) ? 1 : 2;  endfunction
  function automatic int cfg_rbw(input int d); return (d == 0) ? 9 : 12; endfunction
  function automatic bit cfg_zr(input int d);  return d == 1;            endfunction
  function automatic bit cfg_rum(input int d); return d == 0;            endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_bank[d][0] = 1; m_bank[d][1] = 2; m_rb[d] = 0; m_ren[d] = 0; m_rum_on[d] = 0;
    end
  endtask

  task automatic model_write(input int d, input int unsigned a, input int unsigned v, input time tc);
    int unsigned w, b;
    case ((a >> 13) & 3)
      0: m_ren[d] = ((v & 15) == 10);
      1: begin
        w = (cfg_nw(d) == 2) ? ((a >> 11) & 1) : 0;
        b = m_bank[d][w];
        if (((a >> 12) & 1) == 0) b = (b & 32'hFFFF_FF00) | v;
        else                      b = (b & 32'hFF) | (v << 8);
        b = b % (1 << cfg_rbw(d));
        if (cfg_zr(d) && b == 0) b = 1;
        m_bank[d][w] = b;
      end
      2: begin
        m_rb[d] = v & (cfg_rum(d) ? 7 : 15);
        if (cfg_rum(d)) begin
          m_rum_on[d] = ((v >> 3) & 1) == 1;
          m_rum_t[d]  = tc;
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_load(input int d, input logic [63:0] img);
    m_ren[d]     = img[0];
    m_rb[d]      = 32'(img[4:1]);
    m_bank[d][0] = 32'(img[16:5])  % (1 << cfg_rbw(d));
    m_bank[d][1] = 32'(img[28:17]) % (1 << cfg_rbw(d));
    m_rum_on[d]  = 0;
  endtask

  function automatic logic [63:0] ss_image(input int d);
    longint unsigned v;
    v = longint'(m_ren[d]) | (longint'(m_rb[d]) << 1) | (longint'(m_bank[d][0]) << 5);
    if (cfg_nw(d) == 2) v = v | (longint'(m_bank[d][1]) << 17);
    return 64'(v);
  endfunction

  function automatic obs_t expect_obs(input int d, input time ts);
    obs_t        o;
    int unsigned ad, up;
    bit          ren;
    o = '0;
    o.cdo = 8'hFF;
    if (enable) begin
      if (!cart_addr[14]) ad = 32'(cart_addr);
      else begin
        if (cfg_nw(d) == 2) ad = ((m_bank[d][cart_addr[13]] % 1024) << 13) | (cart_addr & 'h1FFF);
        else                ad = ((m_bank[d][0] % 512) << 14) | (cart_addr & 'h3FFF);
        up = (ad >> 14) & rom_mask;
        ad = (up << 14) | (ad & 'h3FFF);
      end
      ren    = m_ren[d] && has_ram;
      o.mbc  = 23'(ad);
      o.cram = 17'(((m_rb[d] & ram_mask) << 13) | (cart_addr & 'h1FFF));
      o.ren  = ren;
      o.cdo  = ren ? cram_di : 8'hFF;
      o.rum  = cfg_rum(d) && m_rum_on[d] && ((ts - m_rum_t[d]) < time'(HOLD_A * PER));
      o.ss   = ss_image(d);
    end
    return o;
  endfunction

  // ---------------- monitor ----------------
  obs_t ea, eb;
  always @(negedge clk_sys) begin
    if (probe) begin
      n_cmp++;
      if (q_a.size() == 0) begin n_bad++; $display("FAIL A_scoreboard: probe with empty queue"); end
      else begin
        ea = q_a.pop_front();
        if (obs_a !== ea) begin
          n_bad++;
          $display("FAIL A_probe t=%0t: got mbc=%h cram=%h do=%h ren=%b rum=%b ss=%h want mbc=%h cram=%h do=%h ren=%b rum=%b ss=%h",
                   $time, obs_a.mbc, obs_a.cram, obs_a.cdo, obs_a.ren, obs_a.rum, obs_a.ss,
                   ea.mbc, ea.cram, ea.cdo, ea.ren, ea.rum, ea.ss);
        end
      end
      n_cmp++;
      if (q_b.size() == 0) begin n_bad++; $display("FAIL B_scoreboard: probe with empty queue"); end
      else begin
        eb = q_b.pop_front();
        if (obs_b !== eb) begin
          n_bad++;
          $display("FAIL B_probe t=%0t: got mbc=%h cram=%h do=%h ren=%b rum=%b ss=%h want mbc=%h cram=%h do=%h ren=%b rum=%b ss=%h",
                   $time, obs_b.mbc, obs_b.cram, obs_b.cdo, obs_b.ren, obs_b.rum, obs_b.ss,
                   eb.mbc, eb.cram, eb.cdo, eb.ren, eb.rum, eb.ss);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_sys); #1;
  endtask

  task automatic push_expect();
    q_a.push_back(expect_obs(0, $time + PER/2 - 1));
    q_b.push_back(expect_obs(1, $time + PER/2 - 1));
  endtask

  task automatic do_probe(input int unsigned a16, input bit en);
    cart_addr = 15'(a16); cart_a15 = 1'((a16 >> 15) & 1); cart_wr = 1'b0;
    enable = en; cram_di = 8'($urandom);
    probe = 1'b1;
    push_expect();
    step();
    probe = 1'b0; enable = 1'b1;
  endtask

  // One write cycle, then an idle cycle that also checks the updated state.
  task automatic do_write(input int unsigned a16, input int unsigned v, input bit en);
    cart_addr = 15'(a16); cart_a15 = 1'((a16 >> 15) & 1); cart_di = 8'(v);
    enable = en; ce_cpu = 1'b1; cart_wr = 1'b1;
    step();
    if (!cart_a15 && en) begin
      model_write(0, a16 & 'h7FFF, v & 'hFF, $time - 1);
      model_write(1, a16 & 'h7FFF, v & 'hFF, $time - 1);
    end
    cart_wr = 1'b0; cram_di = 8'($urandom); probe = 1'b1;
    push_expect();
    step();
    probe = 1'b0; enable = 1'b1;
  endtask

  task automatic do_reset();
    cart_wr = 1'b0; reset_n = 1'b0;
    step(); step();
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic do_ss_load(input logic [63:0] ia, input logic [63:0] ib, input bit with_wr);
    ss_data_a = ia; ss_data_b = ib; savestate_load = 1'b1; ce_cpu = 1'b1;
    cart_wr = with_wr; cart_addr = 15'h2000; cart_a15 = 1'b0; cart_di = 8'h77;
    step();
    savestate_load = 1'b0; cart_wr = 1'b0;
    model_load(0, ia); model_load(1, ib);
    step();
  endtask

  initial begin
    #(PER * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned a, v, r;
    reset_n = 1'b0; ce_cpu = 1'b1; enable = 1'b1; savestate_load = 1'b0; probe = 1'b0;
    ss_data_a = '0; ss_data_b = '0; has_ram = 1'b1; ram_mask = 4'hF; rom_mask = 9'h1FF;
    cart_addr = '0; cart_a15 = 1'b0; cart_wr = 1'b0; cart_di = '0; cram_di = '0;
    model_reset();
    step();
    do_probe('h4123, 1);          // checked while still in reset
    reset_n = 1'b1;
    do_probe('h4123, 1);
    do_probe('h0123, 1);
    do_probe('hA000, 1);

    do_write('h2000, 'h05, 1); do_probe('h4000, 1);
    do_write('h2000, 'h00, 1); do_probe('h4000, 1);
    do_write('h2800, 'h07, 1); do_probe('h6010, 1); do_probe('h4010, 1);
    do_write('h3000, 'h01, 1); do_write('h3800, 'h0A, 1);
    do_probe('h4000, 1); do_probe('h6000, 1);

    // write strobe held across several ce pulses, data changing mid-hold
    cart_addr = 15'h2000; cart_a15 = 1'b0; cart_di = 8'hFF; ce_cpu = 1'b1; cart_wr = 1'b1;
    step();
    model_write(0, 'h2000, 'hFF, $time - 1); model_write(1, 'h2000, 'hFF, $time - 1);
    cart_di = 8'h11;
    for (int i = 0; i < 9; i++) begin ce_cpu = (i % 2 == 1); step(); end
    cart_wr = 1'b0; ce_cpu = 1'b1; step();
    do_write('h3000, 'h01, 1);
    rom_mask = 9'h003;
    do_probe('h4000, 1); do_probe('h7FFF, 1);
    rom_mask = 9'h1FF;
    do_probe('h7FFF, 1);

    // RAM enable, bank select and rumble hold
    do_write('h0000, 'h0A, 1);
    do_write('h4000, 'h0B, 1);
    for (int i = 0; i < 9; i++) do_probe('hA000 + i, 1);
    do_write('h4000, 'h0B, 1); do_probe('hA100, 1); do_probe('hA100, 1);
    do_write('h4000, 'h03, 1); do_probe('hA100, 1);
    has_ram = 1'b0; do_probe('hA100, 1); has_ram = 1'b1;
    ram_mask = 4'h1; do_probe('hB234, 1); ram_mask = 4'hF;
    do_write('h0000, 'h0B, 1); do_probe('hA000, 1);
    do_write('h0000, 'h0A, 1);

    // disabled mapper: idle outputs, no commits
    do_probe('h4000, 0); do_probe('hA000, 0);
    do_write('h2000, 'h33, 0); do_probe('h4000, 1);
    do_write('hA000, 'h44, 1); do_probe('h4000, 1);

    // reset released while a write is still asserted
    cart_addr = 15'h2000; cart_a15 = 1'b0; cart_di = 8'h33; cart_wr = 1'b1; reset_n = 1'b0;
    step(); step();
    model_reset(); reset_n = 1'b1;
    step(); step(); step();
    cart_wr = 1'b0; step();
    do_probe('h4000, 1); do_probe('h6000, 1);

    // savestate round trip through reset
    do_write('h2000, 'h2D, 1); do_write('h2800, 'h13, 1); do_write('h3800, 'h05, 1);
    do_write('h0000, 'h0A, 1); do_write('h4000, 'h06, 1);
    do_probe('h6ABC, 1);
    begin
      logic [63:0] ia, ib;
      ia = ss_image(0); ib = ss_image(1);
      do_reset(); do_probe('h6ABC, 1);
      do_ss_load(ia, ib, 1'b1);
    end
    do_probe('h6ABC, 1); do_probe('h4ABC, 1); do_probe('hBABC, 1);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 35) begin
        a = $urandom_range(0, 'h7FFF);
        if ($urandom_range(0, 9) == 0) a = a | 'h8000;
        v = $urandom_range(0, 255);
        if (((a >> 13) & 3) == 0 && $urandom_range(0, 1) == 1) v = 'h0A;
        do_write(a, v, $urandom_range(0, 14) != 0);
      end else if (r < 39) begin
        do_ss_load({35'd0, 29'($urandom)}, {35'd0, 29'($urandom)}, 1'($urandom_range(0, 1)));
      end else if (r < 41) begin
        do_reset();
      end else begin
        has_ram  = ($urandom_range(0, 3) != 0);
        ram_mask = 4'($urandom);
        rom_mask = ($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'h1FF;
        ce_cpu   = 1'($urandom);
        do_probe($urandom_range(0, 'hFFFF), $urandom_range(0, 9) != 0);
        ce_cpu   = 1'b1;
      end
    end

    step(); step();
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expectations: got %0d/%0d unconsumed want 0/0", q_a.size(), q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
